// File: rtl/design1_pkg.sv
// Shared types and constants for the PL DMA smoke-test block.
package design1_pkg;

    // Burst-master sequencing states.
    typedef enum logic [2:0] {
        StIdle,
        StAw,
        StW,
        StB,
        StDone
    } state_e;

    // Lite register word offsets (addr[3:2]).
    localparam logic [1:0] RegCtrl   = 2'd0;
    localparam logic [1:0] RegStatus = 2'd1;

    // AXI encodings.
    localparam logic [1:0] AxiBurstIncr  = 2'b01;
    localparam logic [2:0] AxiSize4Byte  = 3'b010;
    localparam logic [1:0] AxiRespOkay   = 2'b00;
    localparam logic [1:0] AxiRespSlverr = 2'b10;
    localparam logic [1:0] AxiRespDecerr = 2'b11;

endpackage

// File: rtl/design1_if.sv
// AXI4-Lite control bus and AXI4 write-only burst bus.
interface design1_axil_if #(
    parameter int unsigned AddrWidth = 4
);
    logic [AddrWidth-1:0] awaddr;
    logic                 awvalid;
    logic                 awready;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 wvalid;
    logic                 wready;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;
    logic [AddrWidth-1:0] araddr;
    logic                 arvalid;
    logic                 arready;
    logic [31:0]          rdata;
    logic [1:0]           rresp;
    logic                 rvalid;
    logic                 rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

interface design1_axi_if;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/design1_axil_regs.sv
// AXI4-Lite slave holding CTRL (START) and exposing STATUS (DONE, ERROR).
// start_o pulses for one cycle on a 0->1 write of CTRL[0].
module design1_axil_regs
    import design1_pkg::*;
#(
    parameter int unsigned AddrWidth = 4
) (
    input  logic            aclk,
    input  logic            aresetn,
    design1_axil_if.slave   s_axi,
    input  logic            done_i,
    input  logic            error_i,
    output logic            start_o
);

    logic        wr_ready_q, wr_ready_d;
    logic        bvalid_q, bvalid_d;
    logic        rd_ready_q, rd_ready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ctrl_q, ctrl_d;
    logic        wr_fire, rd_fire;

    logic [AddrWidth-1:0] wr_addr, rd_addr;
    assign wr_addr = s_axi.awaddr;
    assign rd_addr = s_axi.araddr;

    // Only the word index, CTRL data bit and its strobe are decoded.
    logic unused_lite;
    assign unused_lite = ^{wr_addr, rd_addr, s_axi.wdata[31:1], s_axi.wstrb[3:1]};

    // Next-state for both lite channels and the CTRL register.
    always_comb begin
        wr_ready_d = s_axi.awvalid && s_axi.wvalid && !bvalid_q && !wr_ready_q;
        wr_fire    = wr_ready_q && s_axi.awvalid && s_axi.wvalid;
        bvalid_d   = bvalid_q;
        ctrl_d     = ctrl_q;
        start_o    = 1'b0;
        rd_ready_d = s_axi.arvalid && !rvalid_q && !rd_ready_q;
        rd_fire    = rd_ready_q && s_axi.arvalid;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;

        if (wr_fire) begin
            bvalid_d = 1'b1;
            if (wr_addr[3:2] == RegCtrl && s_axi.wstrb[0]) begin
                ctrl_d  = s_axi.wdata[0];
                start_o = s_axi.wdata[0] && !ctrl_q;
            end
        end else if (bvalid_q && s_axi.bready) begin
            bvalid_d = 1'b0;
        end

        if (rd_fire) begin
            rvalid_d = 1'b1;
            case (rd_addr[3:2])
                RegCtrl:   rdata_d = {31'd0, ctrl_q};
                RegStatus: rdata_d = {30'd0, error_i, done_i};
                default:   rdata_d = 32'd0;
            endcase
        end else if (rvalid_q && s_axi.rready) begin
            rvalid_d = 1'b0;
        end
    end

    // Lite slave state registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ready_q <= 1'b0;
            bvalid_q   <= 1'b0;
            rd_ready_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'd0;
            ctrl_q     <= 1'b0;
        end else begin
            wr_ready_q <= wr_ready_d;
            bvalid_q   <= bvalid_d;
            rd_ready_q <= rd_ready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign s_axi.awready = wr_ready_q;
    assign s_axi.wready  = wr_ready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = AxiRespOkay;
    assign s_axi.arready = rd_ready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = AxiRespOkay;

endmodule

// File: rtl/design1_wrapper.sv
// PL DMA smoke-test block: a lite START kicks off C_M_NUM_BURSTS INCR bursts
// writing an incrementing word pattern to DDR, one burst outstanding at a time.
module design1_wrapper
    import design1_pkg::*;
#(
    parameter logic [31:0] C_M_TARGET_BASE_ADDR = 32'h00080000,
    parameter int unsigned C_M_BURST_LEN        = 16,
    parameter int unsigned C_M_NUM_BURSTS       = 16,
    parameter int unsigned C_S_ADDR_WIDTH       = 4
) (
    input  logic            aclk,
    input  logic            aresetn,
    design1_axil_if.slave   s_axi,
    design1_axi_if.master   m_axi,
    output logic            m_axi_txn_done,
    output logic            m_axi_error
);

    localparam logic [31:0] BurstBytes = 32'(C_M_BURST_LEN * 4);
    localparam logic [7:0]  LastBeat   = 8'(C_M_BURST_LEN - 1);
    localparam logic [7:0]  LastBurst  = 8'(C_M_NUM_BURSTS - 1);

    state_e      state_q, state_d;
    logic [7:0]  beat_q, beat_d;
    logic [7:0]  burst_q, burst_d;
    logic [15:0] gbeat_q, gbeat_d;
    logic        error_q, error_d;
    logic        start;

    design1_axil_regs #(
        .AddrWidth (C_S_ADDR_WIDTH)
    ) u_regs (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_axi   (s_axi),
        .done_i  (m_axi_txn_done),
        .error_i (error_q),
        .start_o (start)
    );

    // Only SLVERR/DECERR matter, both of which set bresp[1].
    logic unused_bresp;
    assign unused_bresp = m_axi.bresp[0];

    // Master sequencing: next state, counters and channel valids/ready.
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        burst_d       = burst_q;
        gbeat_d       = gbeat_q;
        error_d       = error_q;
        m_axi.awvalid = 1'b0;
        m_axi.wvalid  = 1'b0;
        m_axi.bready  = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                // START writes while busy are dropped here by construction.
                if (start) begin
                    state_d = StAw;
                    beat_d  = 8'd0;
                    burst_d = 8'd0;
                    gbeat_d = 16'd0;
                    error_d = 1'b0;
                end
            end
            StAw: begin
                m_axi.awvalid = 1'b1;
                if (m_axi.awready) begin
                    state_d = StW;
                end
            end
            StW: begin
                m_axi.wvalid = 1'b1;
                if (m_axi.wready) begin
                    gbeat_d = gbeat_q + 16'd1;
                    if (beat_q == LastBeat) begin
                        beat_d  = 8'd0;
                        state_d = StB;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            StB: begin
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) begin
                    if (m_axi.bresp[1]) begin
                        error_d = 1'b1;
                    end
                    if (burst_q == LastBurst) begin
                        state_d = StDone;
                    end else begin
                        burst_d = burst_q + 8'd1;
                        state_d = StAw;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and counter registers; reset aborts any burst in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
            beat_q  <= 8'd0;
            burst_q <= 8'd0;
            gbeat_q <= 16'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            burst_q <= burst_d;
            gbeat_q <= gbeat_d;
            error_q <= error_d;
        end
    end

    // Payload fields come from registers only, so they hold steady under stalls.
    assign m_axi.awaddr  = C_M_TARGET_BASE_ADDR + ({24'd0, burst_q} * BurstBytes);
    assign m_axi.awlen   = LastBeat;
    assign m_axi.awsize  = AxiSize4Byte;
    assign m_axi.awburst = AxiBurstIncr;
    assign m_axi.wdata   = {16'd0, gbeat_q} + 32'd1;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wlast   = (beat_q == LastBeat);

    assign m_axi_txn_done = (state_q == StDone);
    assign m_axi_error    = error_q;

endmodule

// File: tb/tb_design1_wrapper.sv
// Bench for design1_wrapper: lite master driver, randomly stalling DDR slave
// model and an expected memory image built from the pattern rules.
module tb_design1_wrapper;

    localparam logic [31:0] Base      = 32'h00080000;
    localparam int          BurstLen  = 16;
    localparam int          NumBursts = 16;
    localparam int          NumWords  = BurstLen * NumBursts;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic txn_done;
    logic axi_error;

    always #5 aclk = ~aclk;

    design1_axil_if #(.AddrWidth(4)) s_axi ();
    design1_axi_if m_axi ();

    design1_wrapper #(
        .C_M_TARGET_BASE_ADDR (Base),
        .C_M_BURST_LEN        (BurstLen),
        .C_M_NUM_BURSTS       (NumBursts),
        .C_S_ADDR_WIDTH       (4)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axi          (s_axi),
        .m_axi          (m_axi),
        .m_axi_txn_done (txn_done),
        .m_axi_error    (axi_error)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // DDR slave model state
    logic [31:0] mem [logic [31:0]];
    logic [31:0] aw_q [$];
    int  aw_count, b_count, pending_b, beat;
    int  aw_wait, w_wait, b_wait;
    int  max_stall = 0;
    int  err_burst = -1;
    bit  aw_hold, w_hold, b_fire, aw_rdy, w_rdy;
    logic [31:0] aw_hold_addr, w_hold_data, waddr;
    logic        w_hold_last;

    // Slave decides ready/valid at each negedge; a handshake is known right away.
    initial begin
        m_axi.awready = 1'b0;
        m_axi.wready  = 1'b0;
        m_axi.bvalid  = 1'b0;
        m_axi.bresp   = 2'b00;
        aw_count = 0; b_count = 0; pending_b = 0; beat = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0;
        aw_hold = 0; w_hold = 0; b_fire = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                m_axi.awready = 1'b0;
                m_axi.wready  = 1'b0;
                m_axi.bvalid  = 1'b0;
                pending_b = 0; beat = 0; aw_hold = 0; w_hold = 0; b_fire = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0;
                aw_q.delete();
            end else begin
                // B first so a response never precedes its last data beat.
                if (b_fire) begin
                    m_axi.bvalid = 1'b0;
                    b_fire = 0;
                end
                if (!m_axi.bvalid && pending_b > 0) begin
                    if (b_wait == 0) begin
                        m_axi.bvalid = 1'b1;
                        m_axi.bresp  = (b_count == err_burst) ? 2'b10 : 2'b00;
                    end else begin
                        b_wait--;
                    end
                end
                if (m_axi.bvalid && m_axi.bready) begin
                    check("done_before_last_b", {31'd0, txn_done}, 32'd0);
                    b_fire = 1;
                    pending_b--;
                    b_count++;
                    b_wait = int'($urandom_range(0, max_stall));
                end

                // AW channel
                if (aw_hold) begin
                    check("aw_stall_valid", {31'd0, m_axi.awvalid}, 32'd1);
                    check("aw_stall_addr", m_axi.awaddr, aw_hold_addr);
                end
                aw_rdy = 0;
                if (m_axi.awvalid) begin
                    if (aw_wait == 0) aw_rdy = 1;
                    else aw_wait--;
                end
                m_axi.awready = aw_rdy;
                aw_hold = m_axi.awvalid && !aw_rdy;
                aw_hold_addr = m_axi.awaddr;
                if (m_axi.awvalid && aw_rdy) begin
                    check("awaddr", m_axi.awaddr, Base + 32'(aw_count * BurstLen * 4));
                    check("awlen", {24'd0, m_axi.awlen}, 32'(BurstLen - 1));
                    check("awsize", {29'd0, m_axi.awsize}, 32'd2);
                    check("awburst", {30'd0, m_axi.awburst}, 32'd1);
                    check("aw_outstanding", 32'(aw_q.size() + pending_b), 32'd0);
                    aw_q.push_back(m_axi.awaddr);
                    aw_count++;
                    aw_wait = int'($urandom_range(0, max_stall));
                end

                // W channel
                if (w_hold) begin
                    check("w_stall_valid", {31'd0, m_axi.wvalid}, 32'd1);
                    check("w_stall_data", m_axi.wdata, w_hold_data);
                    check("w_stall_last", {31'd0, m_axi.wlast}, {31'd0, w_hold_last});
                end
                w_rdy = 0;
                if (m_axi.wvalid) begin
                    if (w_wait == 0) w_rdy = 1;
                    else w_wait--;
                end
                m_axi.wready = w_rdy;
                w_hold = m_axi.wvalid && !w_rdy;
                w_hold_data = m_axi.wdata;
                w_hold_last = m_axi.wlast;
                if (m_axi.wvalid && w_rdy) begin
                    if (aw_q.size() == 0) begin
                        check("w_before_aw", 32'd0, 32'd1);
                    end else begin
                        waddr = aw_q[0] + 32'(beat * 4);
                        mem[waddr] = m_axi.wdata;
                        check("wstrb", {28'd0, m_axi.wstrb}, 32'hF);
                        check("wlast", {31'd0, m_axi.wlast}, (beat == BurstLen - 1) ? 32'd1 : 32'd0);
                        beat++;
                        if (beat == BurstLen) begin
                            beat = 0;
                            void'(aw_q.pop_front());
                            pending_b++;
                        end
                    end
                    w_wait = int'($urandom_range(0, max_stall));
                end
            end
        end
    end

    task automatic lite_write(input logic [3:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output logic [1:0] resp);
        int n;
        @(negedge aclk);
        s_axi.awaddr = addr; s_axi.wdata = data; s_axi.wstrb = strb;
        s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_axi.awready && n < 50);
        if (!s_axi.awready) check("lite_aw_timeout", 32'd0, 32'd1);
        check("lite_wready_with_awready", {31'd0, s_axi.wready}, {31'd0, s_axi.awready});
        @(negedge aclk);
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b1;
        n = 0;
        while (!s_axi.bvalid && n < 50) begin @(negedge aclk); n++; end
        if (!s_axi.bvalid) check("lite_b_timeout", 32'd0, 32'd1);
        resp = s_axi.bresp;
        @(negedge aclk);
        s_axi.bready = 1'b0;
    endtask

    task automatic lite_read(input logic [3:0] addr, output logic [31:0] data,
                             output logic [1:0] resp);
        int n;
        @(negedge aclk);
        s_axi.araddr = addr; s_axi.arvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_axi.arready && n < 50);
        if (!s_axi.arready) check("lite_ar_timeout", 32'd0, 32'd1);
        @(negedge aclk);
        s_axi.arvalid = 1'b0; s_axi.rready = 1'b1;
        n = 0;
        while (!s_axi.rvalid && n < 50) begin @(negedge aclk); n++; end
        if (!s_axi.rvalid) check("lite_r_timeout", 32'd0, 32'd1);
        data = s_axi.rdata;
        resp = s_axi.rresp;
        @(negedge aclk);
        s_axi.rready = 1'b0;
    endtask

    task automatic clear_model();
        @(posedge aclk);
        aw_count = 0;
        b_count = 0;
        mem.delete();
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!txn_done && n < 4000) begin @(negedge aclk); n++; end
        if (!txn_done) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_aw(input int cnt);
        int n;
        n = 0;
        while (aw_count < cnt && n < 2000) begin @(negedge aclk); n++; end
        if (aw_count < cnt) check("aw_wait_timeout", 32'(aw_count), 32'(cnt));
    endtask

    // Expected image: word i at Base + 4*i holds i+1, nothing else written.
    task automatic check_image(input string tag);
        logic [31:0] a, v;
        for (int i = 0; i < NumWords; i++) begin
            a = Base + 32'(4 * i);
            v = mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
            check($sformatf("%s_mem[%0d]", tag, i), v, 32'(i + 1));
        end
        check({tag, "_mem_words"}, 32'(mem.num()), 32'(NumWords));
        check({tag, "_aw_count"}, 32'(aw_count), 32'(NumBursts));
        check({tag, "_b_count"}, 32'(b_count), 32'(NumBursts));
    endtask

    logic [31:0] rd;
    logic [1:0]  rsp;

    initial begin
        s_axi.awaddr = '0; s_axi.awvalid = 1'b0; s_axi.wdata = '0; s_axi.wstrb = '0;
        s_axi.wvalid = 1'b0; s_axi.bready = 1'b0; s_axi.araddr = '0;
        s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;

        // Reset state
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        check("rst_awvalid", {31'd0, m_axi.awvalid}, 32'd0);
        check("rst_wvalid", {31'd0, m_axi.wvalid}, 32'd0);
        check("rst_bready", {31'd0, m_axi.bready}, 32'd0);
        check("rst_txn_done", {31'd0, txn_done}, 32'd0);
        check("rst_error", {31'd0, axi_error}, 32'd0);
        check("rst_lite_readies", {29'd0, s_axi.awready, s_axi.wready, s_axi.arready}, 32'd0);
        check("rst_lite_valids", {30'd0, s_axi.bvalid, s_axi.rvalid}, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        lite_read(4'h0, rd, rsp);
        check("rst_ctrl", rd, 32'd0);
        lite_read(4'h4, rd, rsp);
        check("rst_status", rd, 32'd0);

        // Unmapped words and strobe gating
        lite_write(4'h8, 32'hFFFF_FFFF, 4'hF, rsp);
        lite_read(4'h8, rd, rsp);
        check("reg8_reads_zero", rd, 32'd0);
        lite_read(4'hC, rd, rsp);
        check("regC_reads_zero", rd, 32'd0);
        lite_write(4'h0, 32'h1, 4'h0, rsp);
        lite_read(4'h0, rd, rsp);
        check("ctrl_strobe_gated", rd, 32'd0);
        repeat (5) @(negedge aclk);
        check("no_start_no_aw", 32'(aw_count), 32'd0);

        // Run 1: memory always ready
        max_stall = 0;
        clear_model();
        lite_write(4'h0, 32'h1, 4'hF, rsp);
        check("ctrl_bresp", {30'd0, rsp}, 32'd0);
        lite_read(4'h0, rd, rsp);
        check("ctrl_readback", rd, 32'd1);
        check("ctrl_rresp", {30'd0, rsp}, 32'd0);
        wait_done("run1");
        check_image("run1");
        check("run1_first_word", mem.exists(Base) ? mem[Base] : 32'hDEAD_BEEF, 32'h1);
        check("run1_word_3c", mem.exists(Base + 32'h3C) ? mem[Base + 32'h3C] : 32'hDEAD_BEEF,
              32'h10);
        check("run1_last_word", mem.exists(Base + 32'h3FC) ? mem[Base + 32'h3FC] : 32'hDEAD_BEEF,
              32'h100);
        lite_read(4'h4, rd, rsp);
        check("run1_status", rd, 32'h1);

        // Run 2: random stalls and a START toggle while busy
        max_stall = 5;
        clear_model();
        lite_write(4'h0, 32'h0, 4'hF, rsp);
        lite_write(4'h0, 32'h1, 4'hF, rsp);
        lite_read(4'h4, rd, rsp);
        check("run2_status_busy", rd, 32'h0);
        wait_aw(3);
        lite_write(4'h0, 32'h0, 4'hF, rsp);
        lite_write(4'h0, 32'h1, 4'hF, rsp);
        wait_done("run2");
        check_image("run2");
        repeat (40) @(negedge aclk);
        check("run2_no_retrigger", 32'(aw_count), 32'(NumBursts));
        lite_read(4'h4, rd, rsp);
        check("run2_status", rd, 32'h1);

        // Run 3: SLVERR on burst 3, then restart clears ERROR
        err_burst = 3;
        clear_model();
        lite_write(4'h0, 32'h0, 4'hF, rsp);
        lite_write(4'h0, 32'h1, 4'hF, rsp);
        wait_done("run3");
        check_image("run3");
        check("run3_error_out", {31'd0, axi_error}, 32'd1);
        lite_read(4'h4, rd, rsp);
        check("run3_status", rd, 32'h3);
        err_burst = -1;
        lite_write(4'h0, 32'h0, 4'hF, rsp);
        lite_read(4'h4, rd, rsp);
        check("run3_status_sticky", rd, 32'h3);
        clear_model();
        lite_write(4'h0, 32'h1, 4'hF, rsp);
        check("rerun_error_cleared", {31'd0, axi_error}, 32'd0);
        wait_done("rerun");
        check_image("rerun");
        lite_read(4'h4, rd, rsp);
        check("rerun_status", rd, 32'h1);

        // Run 4: reset during burst 5, then restart from the base address
        clear_model();
        lite_write(4'h0, 32'h0, 4'hF, rsp);
        lite_write(4'h0, 32'h1, 4'hF, rsp);
        wait_aw(6);
        @(negedge aclk);
        #2 aresetn = 1'b0;
        #1;
        check("midrst_awvalid", {31'd0, m_axi.awvalid}, 32'd0);
        check("midrst_wvalid", {31'd0, m_axi.wvalid}, 32'd0);
        check("midrst_bready", {31'd0, m_axi.bready}, 32'd0);
        check("midrst_done", {31'd0, txn_done}, 32'd0);
        repeat (2) @(negedge aclk);
        clear_model();
        @(negedge aclk);
        aresetn = 1'b1;
        lite_read(4'h0, rd, rsp);
        check("midrst_ctrl", rd, 32'd0);
        lite_read(4'h4, rd, rsp);
        check("midrst_status", rd, 32'd0);
        check("midrst_no_aw", 32'(aw_count), 32'd0);
        lite_write(4'h0, 32'h1, 4'hF, rsp);
        wait_done("run4");
        check_image("run4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
